// File: rtl/pov_spi_loader_pkg.sv
// Shared fixed-point definitions for the POV loader.
//   Qm, Qn, QMN : integer bits, fraction bits, total word width (Q12.12).
//   NWORDS      : words per POV frame (playerX/Y, facingX/Y, vplaneX/Y).
//   POV_DEF_*   : power-on POV words loaded into staging and outputs on reset.
//   load_state_e: receive FSM state encoding.
package pov_spi_loader_pkg;

  localparam int Qm     = 12;
  localparam int Qn     = 12;
  localparam int QMN    = Qm + Qn;
  localparam int NWORDS = 6;

  // Fixed-point constants expressed as multiples of 2^Qn.
  localparam logic [QMN-1:0] POV_DEF_PX = QMN'(3 << (Qn - 1)); // 1.5
  localparam logic [QMN-1:0] POV_DEF_PY = QMN'(3 << (Qn - 1)); // 1.5
  localparam logic [QMN-1:0] POV_DEF_FX = '0;                  // 0.0
  localparam logic [QMN-1:0] POV_DEF_FY = QMN'(1 << Qn);       // 1.0
  localparam logic [QMN-1:0] POV_DEF_VX = QMN'(1 << (Qn - 1)); // 0.5
  localparam logic [QMN-1:0] POV_DEF_VY = '0;                  // 0.0

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } load_state_e;

endpackage

// File: rtl/pov_spi_loader_spi_input_sync.sv
// spi_input_sync: brings the three asynchronous SPI pins into the clk domain.
//   clk, reset           : system clock, synchronous active-high reset
//   i_sclk/i_mosi/i_ss_n : raw SPI pins
//   mosi_s, ss_n_s       : 2-flop synchronized levels
//   sclk_rise            : one-cycle pulse on a synchronized sclk rise
//   ss_n_rise/ss_n_fall  : one-cycle pulses on synchronized select edges
// mosi_s comes from the same stage as the sclk edge detector input, so the
// bit presented alongside sclk_rise is the one that was on the pin at the
// SPI rising edge.
module spi_input_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_sclk,
  input  logic i_mosi,
  input  logic i_ss_n,
  output logic mosi_s,
  output logic ss_n_s,
  output logic sclk_rise,
  output logic ss_n_rise,
  output logic ss_n_fall
);

  // [0] first sync flop, [1] second sync flop, [2] edge-detect history
  logic [2:0] sclk_sr;
  logic [2:0] ss_n_sr;
  logic [1:0] mosi_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sr <= 3'b000;
      ss_n_sr <= 3'b111; // deselected
      mosi_sr <= 2'b00;
    end else begin
      sclk_sr <= {sclk_sr[1:0], i_sclk};
      ss_n_sr <= {ss_n_sr[1:0], i_ss_n};
      mosi_sr <= {mosi_sr[0], i_mosi};
    end
  end

  assign mosi_s    = mosi_sr[1];
  assign ss_n_s    = ss_n_sr[1];
  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign ss_n_rise = ss_n_sr[1] & ~ss_n_sr[2];
  assign ss_n_fall = ~ss_n_sr[1] & ss_n_sr[2];

endmodule

// File: rtl/pov_spi_loader.sv
// pov_spi_loader: receives a POV frame over SPI (mode 0, MSB first), stages
// it, and commits it to the output buses only on i_frame_end so the
// consumers never see a torn vector set mid-frame.
//   clk, reset          : system clock, synchronous active-high reset
//   i_sclk/i_mosi/i_ss_n: asynchronous SPI pins
//   i_frame_end         : one-cycle commit strobe at end of visible frame
//   playerX..vplaneY    : committed POV words
//   o_pending           : a complete frame is staged and not yet committed
//   o_committed         : one-cycle pulse in the cycle the outputs update
module pov_spi_loader #(
  parameter int QMN    = pov_spi_loader_pkg::QMN,
  parameter int NWORDS = pov_spi_loader_pkg::NWORDS
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_sclk,
  input  logic           i_mosi,
  input  logic           i_ss_n,
  input  logic           i_frame_end,
  output logic [QMN-1:0] playerX,
  output logic [QMN-1:0] playerY,
  output logic [QMN-1:0] facingX,
  output logic [QMN-1:0] facingY,
  output logic [QMN-1:0] vplaneX,
  output logic [QMN-1:0] vplaneY,
  output logic           o_pending,
  output logic           o_committed
);

  import pov_spi_loader_pkg::*;

  localparam int FW = NWORDS * QMN;
  localparam int CW = $clog2(FW + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);

  // First word in the frame sits in the most significant slot.
  localparam logic [FW-1:0] DEF_FRAME = FW'({QMN'(POV_DEF_PX), QMN'(POV_DEF_PY),
                                             QMN'(POV_DEF_FX), QMN'(POV_DEF_FY),
                                             QMN'(POV_DEF_VX), QMN'(POV_DEF_VY)});

  logic mosi_s, ss_n_s, sclk_rise, ss_n_rise, ss_n_fall;

  spi_input_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .i_sclk    (i_sclk),
    .i_mosi    (i_mosi),
    .i_ss_n    (i_ss_n),
    .mosi_s    (mosi_s),
    .ss_n_s    (ss_n_s),
    .sclk_rise (sclk_rise),
    .ss_n_rise (ss_n_rise),
    .ss_n_fall (ss_n_fall)
  );

  load_state_e   state, state_next;
  logic [CW-1:0] bit_cnt;
  logic [FW-1:0] shift_q, shift_next;
  logic [FW-1:0] stage_q;
  logic [FW-1:0] out_q;
  logic          start, shift_en, load_stage;

  assign shift_next = {shift_q[FW-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    load_stage = 1'b0;
    case (state)
      // A fresh select edge, or a select already held low (e.g. across a
      // reset), both begin a transfer at bit 0.
      ST_IDLE: begin
        if (ss_n_fall || !ss_n_s) begin
          start      = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      // Deselect before the last bit is an abort: partial data is dropped
      // and staging keeps whatever it held.
      ST_SHIFT: begin
        if (ss_n_rise) begin
          state_next = ST_IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            load_stage = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      // Surplus clocks in the same select are ignored.
      ST_DONE: begin
        if (ss_n_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      stage_q     <= DEF_FRAME;
      out_q       <= DEF_FRAME;
      o_pending   <= 1'b0;
      o_committed <= 1'b0;
    end else begin
      o_committed <= 1'b0;

      if (start) begin
        bit_cnt <= '0;
        shift_q <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + CW'(1);
        shift_q <= shift_next;
      end

      // Commit reads stage_q before any same-cycle load, so a frame that
      // completes together with i_frame_end waits for the next strobe.
      if (i_frame_end && o_pending) begin
        out_q       <= stage_q;
        o_pending   <= 1'b0;
        o_committed <= 1'b1;
      end

      // Placed after the commit so a same-cycle completion leaves pending set.
      if (load_stage) begin
        stage_q   <= shift_next;
        o_pending <= 1'b1;
      end
    end
  end

  assign playerX = out_q[FW-1         -: QMN];
  assign playerY = out_q[FW-1 - QMN   -: QMN];
  assign facingX = out_q[FW-1 - 2*QMN -: QMN];
  assign facingY = out_q[FW-1 - 3*QMN -: QMN];
  assign vplaneX = out_q[FW-1 - 4*QMN -: QMN];
  assign vplaneY = out_q[FW-1 - 5*QMN -: QMN];

endmodule

// File: doc/pov_spi_loader.md
# pov_spi_loader

- Upstream stage of the view/debug path.
- Receives a complete point-of-view (POV) from an external SPI host: player position, facing vector and viewplane vector, as six signed fixed-point words.
- Double-buffers the received POV and commits it only at frame end, so the tracer and debug overlay never see a torn vector set mid-frame.
- Drives the `playerX..vplaneY` buses consumed by the debug overlay and the ray tracer.

## Interface

Parameters:
- `QMN`, default `` `Qm+`Qn `` from the shared fixed-point header: width of each POV word.
- `NWORDS`, default 6, fixed: number of words per frame (`playerX`, `playerY`, `facingX`, `facingY`, `vplaneX`, `vplaneY`).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system/pixel clock.
- `reset` in 1: synchronous, active-high.
- `i_sclk` in 1: SPI clock, asynchronous to `clk`; mode 0, sampled on rising edge.
- `i_mosi` in 1: SPI data, MSB first, asynchronous.
- `i_ss_n` in 1: SPI select, active-low, asynchronous.
- `i_frame_end` in 1: one-cycle pulse at end of visible frame; the commit strobe.
- `playerX`, `playerY`, `facingX`, `facingY`, `vplaneX`, `vplaneY` out `QMN` each: committed POV.
- `o_pending` out 1: a complete POV is staged and not yet committed.
- `o_committed` out 1: one-cycle pulse when outputs update.

## Operation

- `i_sclk`, `i_mosi` and `i_ss_n` each pass through a 2-flop synchronizer; a third register provides edge detection.
- Data is sampled on a detected `sclk` rise; `mosi` uses the synchronized value aligned with that edge.
- FSM states:
  - IDLE: waits for synchronized `ss_n` = 0, then clears the bit counter and goes to SHIFT.
  - SHIFT: each `sclk` rise shifts `mosi` into the LSB of a `NWORDS*QMN`-bit shift register and increments the counter.
    - When the counter reaches `NWORDS*QMN`, copy the shift register to staging, set `o_pending`, go to DONE.
    - On `ss_n` rise before the count completes (abort), discard the partial data, leave staging untouched, go to IDLE.
  - DONE: ignores further `sclk` edges and waits for `ss_n` = 1, then goes to IDLE.
- Word order within a frame: first bit received is `playerX[QMN-1]`; last bit is `vplaneY[0]`.
- A new complete frame while `o_pending` = 1 overwrites staging; `o_pending` stays 1.
- Commit on `i_frame_end` with `o_pending` = 1:
  - all six outputs are loaded from staging in the same cycle;
  - `o_pending` clears;
  - `o_committed` pulses.
- `i_frame_end` with `o_pending` = 0 has no effect.
- Same-cycle completion and `i_frame_end`:
  - commit uses the staging contents from before that cycle, only if `o_pending` was already 1;
  - the new frame lands in staging with `o_pending` = 1.
- Reset values:
  - FSM = IDLE, counter = 0, shift register = 0, `o_pending` = 0, `o_committed` = 0;
  - staging and outputs = defaults `playerX` = `playerY` = 1.5, `facingX` = 0.0, `facingY` = 1.0, `vplaneX` = 0.5, `vplaneY` = 0.0.
- Reset mid-transfer returns the FSM to IDLE. If `ss_n` is still low after reset, a new transfer starts at bit 0; the host must deselect and reselect.

## Timing

- Sync latency: 3 `clk` from a pin edge to its detected edge.
- `sclk` high and low times must each be ≥ 4 `clk` periods; `ss_n` setup and hold around the first and last `sclk` edge must each be ≥ 4 `clk` periods.
- Completion: `o_pending` rises 1 `clk` after the detected final `sclk` rise.
- Commit: outputs and `o_committed` update in the cycle after `i_frame_end` is sampled high. Outputs are otherwise stable; they never change except on commit or reset.
- `o_committed` is high for exactly 1 cycle.

## Structure

- Shared fixed-point header:
  - `Qm`, `Qn`, `QMN`, the `` `F `` vector macro;
  - POV default constants (`POV_DEF_PX` … `POV_DEF_VY`);
  - `NWORDS`.
- One sub-module, `spi_input_sync`: 2-flop synchronizer plus edge detector for the three SPI pins, outputting synced levels plus `sclk_rise` and `ss_n_rise`/`ss_n_fall` pulses.
- Top level holds the FSM, counter, shift register, staging and output registers.

## Test plan

Scenarios run with Q12.12 (`QMN` = 24, 144-bit frame).
- Reset, then idle → outputs equal 0x001800, 0x001800, 0x000000, 0x001000, 0x000800, 0x000000; `o_pending` = 0.
- Send 144 bits of 0x002000, 0x003000, 0xFFF000, 0x000000, 0x000000, 0x000800, then pulse `i_frame_end` → outputs unchanged before the pulse; exactly those values one cycle after; `o_committed` pulses once; `o_pending` returns to 0.
- Abort: raise `ss_n` after 100 bits, then `i_frame_end` → no commit, outputs unchanged, `o_pending` = 0; a following full frame commits correctly.
- Two complete frames A then B before one `i_frame_end` → outputs equal B; a single `o_committed`.
- Completion and `i_frame_end` in the same cycle with `o_pending` = 0 → no commit that cycle; `o_pending` = 1; the next `i_frame_end` commits the frame.
- 150 `sclk` pulses in one select, then `reset` asserted during a second transfer → first 144 bits are staged and the extra 6 ignored; reset restores the defaults and clears `o_pending`.
